// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown sequencer: FSM encoding and default width.
package countdown_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/down_counter_ld.sv
// Loadable down-counter; a load takes precedence over a decrement enable.
module down_counter_ld #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= q - 1'b1;
    end
  end

endmodule

// File: rtl/countdown_sequencer.sv
// Programmable countdown sequencer: load N, arm, count down to a one-cycle done pulse,
// optionally reloading N for periodic operation.
module countdown_sequencer
  import countdown_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_count,
  input  logic             cfg_reload,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] n_val;
  logic             reload;
  logic             cnt_load;
  logic             cnt_en;
  logic [WIDTH-1:0] cnt_load_val;
  logic             at_terminal;

  assign cfg_ready   = (state == IDLE);
  assign busy        = (state == ARMED) || (state == RUN);
  assign at_terminal = (count == ONE);

  // Counter control mirrors the FSM priority: abort > pause > terminal/decrement.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    cnt_load_val = '0;
    case (state)
      IDLE: begin
        if (cfg_valid && (cfg_count != '0)) begin
          cnt_load     = 1'b1;
          cnt_load_val = cfg_count;
        end
      end
      ARMED: begin
        if (abort) begin
          cnt_load = 1'b1;
        end else if (start) begin
          cnt_load     = 1'b1;
          cnt_load_val = n_val;
        end
      end
      RUN: begin
        if (abort) begin
          cnt_load = 1'b1;
        end else if (!pause) begin
          if (at_terminal && reload) begin
            cnt_load     = 1'b1;
            cnt_load_val = n_val;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      n_val  <= '0;
      reload <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            if (cfg_count != '0) begin
              n_val  <= cfg_count;
              reload <= cfg_reload;
              state  <= ARMED;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ARMED: begin
          if (abort) begin
            state <= IDLE;
          end else if (start) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (!pause && at_terminal) begin
            done <= 1'b1;
            if (!reload) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  down_counter_ld #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(cnt_load_val),
    .en      (cnt_en),
    .q       (count)
  );

endmodule
